// File: rtl/game_state_controller.sv
// game_state_controller: collision-driven life/death sequencer for the
// mario/goomba movers. Watches the goomba mover's `lose` level, freezes play
// through a timed death sequence, decrements lives, then either holds the
// movers in reset for a timed respawn or parks in game over.
//
// Optional feature: define GAME_CONTINUE_EN to let `start` leave GAME_OVER
// (reloads lives and respawns). Without it GAME_OVER is left only by reset.
module game_state_controller #(
  parameter int START_LIVES   = 3,
  parameter int TICK_DIVIDER  = 416667,
  parameter int DEATH_TICKS   = 60,
  parameter int RESPAWN_TICKS = 2
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       lose,
  input  logic       start,
  output logic       movers_reset,
  output logic       freeze,
  output logic       mario_dying,
  output logic       game_over,
  output logic [3:0] lives,
  output logic [4:0] leds
);

  localparam int PW        = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam int DWELL_MAX = (DEATH_TICKS > RESPAWN_TICKS) ? DEATH_TICKS : RESPAWN_TICKS;
  localparam int DW        = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIVIDER - 1);
  localparam logic [DW-1:0] DEATH_LAST   = DW'(DEATH_TICKS - 1);
  localparam logic [DW-1:0] RESPAWN_LAST = DW'(RESPAWN_TICKS - 1);
  localparam logic [3:0]    LIVES_INIT   = 4'(START_LIVES);

  typedef enum logic [1:0] {
    S_RESPAWN,
    S_PLAYING,
    S_DYING,
    S_GAME_OVER
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic          tick;
  logic [DW-1:0] dwell;
  logic          lose_s;
  logic          lose_q;
  logic          lose_rise;
  logic          lives_dec;
  logic          lives_load;

  assign tick      = (presc == PRESC_LAST);
  // lose_s is the sampled collision level, lose_q its previous sample; the
  // rise is acted on one edge after `lose` is first seen high.
  assign lose_rise = lose_s & ~lose_q;

  // Free-running prescaler; only reset clears it, so state changes keep phase.
  always_ff @(posedge vga_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Two-stage sampler for collision edge detection, running in every state.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      lose_s <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      lose_s <= lose;
      lose_q <= lose_s;
    end
  end

  // State register.
  always_ff @(posedge vga_clock) begin
    if (reset) state <= S_RESPAWN;
    else       state <= state_next;
  end

  // Next-state logic plus lives update strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned, which would infer a latch.
    state_next = state;
    lives_dec  = 1'b0;
    lives_load = 1'b0;
    case (state)
      S_RESPAWN: begin
        if (tick && dwell == RESPAWN_LAST) state_next = S_PLAYING;
      end
      S_PLAYING: begin
        if (lose_rise) begin
          state_next = S_DYING;
          lives_dec  = 1'b1;
        end
      end
      S_DYING: begin
        if (tick && dwell == DEATH_LAST)
          state_next = (lives == 4'd0) ? S_GAME_OVER : S_RESPAWN;
      end
      S_GAME_OVER: begin
`ifdef GAME_CONTINUE_EN
        if (start) begin
          state_next = S_RESPAWN;
          lives_load = 1'b1;
        end
`endif
      end
      default: state_next = S_RESPAWN;
    endcase
  end

`ifndef GAME_CONTINUE_EN
  // Continue is compiled out; the button has no function in this build.
  logic unused_start;
  assign unused_start = start;
`endif

  // Dwell counter: restarts on every state entry, counts ticks inside a state.
  always_ff @(posedge vga_clock) begin
    if (reset || state_next != state) dwell <= '0;
    else if (tick)                    dwell <= dwell + 1'b1;
  end

  // Life counter: loaded on reset/continue, saturating decrement on death.
  always_ff @(posedge vga_clock) begin
    if (reset)                         lives <= LIVES_INIT;
    else if (lives_load)               lives <= LIVES_INIT;
    else if (lives_dec && lives != '0) lives <= lives - 4'd1;
  end

  // Moore output decode straight from the state register.
  always_comb begin
    movers_reset = (state == S_RESPAWN);
    freeze       = (state != S_PLAYING);
    mario_dying  = (state == S_DYING);
    game_over    = (state == S_GAME_OVER);
    leds         = {game_over, lives};
  end

endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: scenario tasks plus a randomized run, all checked
// against a cycle-level behavioural model (tick countdowns, integer lives).
// Build with or without GAME_CONTINUE_EN, matching the RTL build.
module tb_game_state_controller;

  localparam int TD = 4;
  localparam int DT = 3;
  localparam int RT = 2;
  localparam int SL = 2;

  logic       vga_clock = 1'b0;
  logic       reset;
  logic       lose;
  logic       start;
  logic       movers_reset;
  logic       freeze;
  logic       mario_dying;
  logic       game_over;
  logic [3:0] lives;
  logic [4:0] leds;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  game_state_controller #(
    .START_LIVES  (SL),
    .TICK_DIVIDER (TD),
    .DEATH_TICKS  (DT),
    .RESPAWN_TICKS(RT)
  ) dut (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .lose        (lose),
    .start       (start),
    .movers_reset(movers_reset),
    .freeze      (freeze),
    .mario_dying (mario_dying),
    .game_over   (game_over),
    .lives       (lives),
    .leds        (leds)
  );

  always #5 vga_clock = ~vga_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: what phase of play we are in, ticks left before a
  // timed phase ends, integer lives, and the last two sampled lose levels.
  typedef enum {M_RESPAWN, M_PLAYING, M_DYING, M_OVER} mode_t;
  mode_t m_mode;
  int    m_presc;
  int    m_left;
  int    m_lives;
  bit    m_ls;
  bit    m_lq;

  task automatic model_update();
    bit tk;
    bit rise;
    if (reset) begin
      m_mode = M_RESPAWN; m_left = RT; m_presc = 0; m_lives = SL;
      m_ls = 1'b0; m_lq = 1'b0;
    end else begin
      tk      = (m_presc == TD - 1);
      m_presc = (m_presc + 1) % TD;
      rise    = m_ls && !m_lq;
      case (m_mode)
        M_RESPAWN: if (tk) begin
          m_left--;
          if (m_left == 0) m_mode = M_PLAYING;
        end
        M_PLAYING: if (rise) begin
          m_mode = M_DYING; m_left = DT;
          if (m_lives > 0) m_lives--;
        end
        M_DYING: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_lives == 0) m_mode = M_OVER;
            else begin m_mode = M_RESPAWN; m_left = RT; end
          end
        end
        M_OVER: begin
`ifdef GAME_CONTINUE_EN
          if (start) begin m_mode = M_RESPAWN; m_left = RT; m_lives = SL; end
`endif
        end
        default: ;
      endcase
      m_lq = m_ls;
      m_ls = lose;
    end
  endtask

  function automatic logic [12:0] dut_outs();
    return {movers_reset, freeze, mario_dying, game_over, lives, leds};
  endfunction

  function automatic logic [12:0] model_outs();
    logic [3:0] l;
    logic       go;
    l  = 4'(m_lives);
    go = (m_mode == M_OVER);
    return {m_mode == M_RESPAWN, m_mode != M_PLAYING, m_mode == M_DYING, go, l, go, l};
  endfunction

  // One clock: model steps on the same inputs the DUT samples, then we
  // return at the falling edge where outputs are stable.
  task automatic tick_clk();
    @(posedge vga_clock);
    model_update();
    @(negedge vga_clock);
    cyc_no++;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; lose = 1'b0; start = 1'b0;
    tick_clk(); tick_clk();
    checks++;
    if (dut_outs() !== model_outs()) begin
      errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
    end
    checks++;
    if ({movers_reset, freeze, mario_dying, game_over} !== 4'b1100 || lives !== 4'd2 || leds !== 5'b00010) begin
      errors++; $display("FAIL reset_values got=%b lives=%0d leds=%b exp=1100 lives=2 leds=00010",
                         {movers_reset, freeze, mario_dying, game_over}, lives, leds);
    end
    reset = 1'b0;
    n = 0;
    while (freeze === 1'b1 && n < 20) begin
      tick_clk(); n++;
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL release_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
    end
    checks++;
    if (n < 1 || n > 8) begin
      errors++; $display("FAIL release_to_playing took=%0d cycles expected 1..8", n);
    end
    checks++;
    if (freeze !== 1'b0 || movers_reset !== 1'b0 || lives !== 4'd2 || leds !== 5'b00010) begin
      errors++; $display("FAIL playing_values freeze=%b mr=%b lives=%0d leds=%b exp 0 0 2 00010",
                         freeze, movers_reset, lives, leds);
    end
  endtask

  task automatic test_single_death();
    int idle;
    int dur;
    idle = $urandom_range(0, 7);
    for (int i = 0; i < idle; i++) begin
      tick_clk();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL idle_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
    end
    lose = 1'b1; tick_clk(); lose = 1'b0;
    checks++;
    if (mario_dying !== 1'b0) begin
      errors++; $display("FAIL death_early mario_dying=%b exp=0", mario_dying);
    end
    tick_clk();
    checks++;
    if (mario_dying !== 1'b1 || lives !== 4'd1 || freeze !== 1'b1) begin
      errors++; $display("FAIL death_latency dying=%b lives=%0d freeze=%b exp 1 1 1", mario_dying, lives, freeze);
    end
    dur = 1;
    while (mario_dying === 1'b1 && dur < 30) begin
      tick_clk();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL dying_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
      if (mario_dying === 1'b1) dur++;
    end
    checks++;
    if (dur < 9 || dur > 12) begin
      errors++; $display("FAIL dying_duration got=%0d exp=9..12", dur);
    end
    checks++;
    if (movers_reset !== 1'b1) begin
      errors++; $display("FAIL respawn_entry movers_reset=%b exp=1", movers_reset);
    end
    dur = 1;
    while (movers_reset === 1'b1 && dur < 30) begin
      tick_clk();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL respawn_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
      if (movers_reset === 1'b1) dur++;
    end
    checks++;
    if (dur < 5 || dur > 8) begin
      errors++; $display("FAIL respawn_duration got=%0d exp=5..8", dur);
    end
    checks++;
    if (freeze !== 1'b0 || lives !== 4'd1) begin
      errors++; $display("FAIL after_respawn freeze=%b lives=%0d exp 0 1", freeze, lives);
    end
  endtask

  task automatic test_held_collision();
    int n;
    reset = 1'b1; tick_clk(); reset = 1'b0;
    n = 0;
    while (freeze === 1'b1 && n < 20) begin
      tick_clk(); n++;
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL held_start_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
    end
    lose = 1'b1;
    tick_clk(); tick_clk();
    checks++;
    if (mario_dying !== 1'b1 || lives !== 4'd1) begin
      errors++; $display("FAIL held_first_death dying=%b lives=%0d exp 1 1", mario_dying, lives);
    end
    n = 0;
    while (freeze === 1'b1 && n < 40) begin
      tick_clk(); n++;
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL held_seq_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      checks++;
      if (freeze !== 1'b0 || lives !== 4'd1 || mario_dying !== 1'b0) begin
        errors++; $display("FAIL held_no_death freeze=%b lives=%0d dying=%b exp 0 1 0", freeze, lives, mario_dying);
      end
    end
    lose = 1'b0; tick_clk();
    lose = 1'b1; tick_clk(); tick_clk();
    lose = 1'b0;
    checks++;
    if (mario_dying !== 1'b1 || lives !== 4'd0) begin
      errors++; $display("FAIL held_second_death dying=%b lives=%0d exp 1 0", mario_dying, lives);
    end
  endtask

  task automatic test_game_over();
    int n;
    n = 0;
    while (game_over !== 1'b1 && n < 30) begin
      tick_clk(); n++;
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL to_over_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
    end
    checks++;
    if (dut_outs() !== 13'b0101_0000_10000) begin
      errors++; $display("FAIL game_over_values got=%b exp=0101000010000", dut_outs());
    end
    for (int i = 0; i < 24; i++) begin
      lose = (i % 4 == 1);
      tick_clk();
      checks++;
      if (dut_outs() !== 13'b0101_0000_10000 || dut_outs() !== model_outs()) begin
        errors++; $display("FAIL game_over_hold got=%b exp=0101000010000", dut_outs());
      end
    end
    lose = 1'b0;
  endtask

  task automatic test_continue();
    start = 1'b1; tick_clk(); start = 1'b0;
`ifdef GAME_CONTINUE_EN
    checks++;
    if (movers_reset !== 1'b1 || lives !== 4'd2 || game_over !== 1'b0 || freeze !== 1'b1) begin
      errors++; $display("FAIL continue mr=%b lives=%0d go=%b freeze=%b exp 1 2 0 1",
                         movers_reset, lives, game_over, freeze);
    end
`else
    for (int i = 0; i < 100; i++) begin
      tick_clk();
      checks++;
      if (game_over !== 1'b1 || lives !== 4'd0 || dut_outs() !== model_outs()) begin
        errors++; $display("FAIL no_continue go=%b lives=%0d exp 1 0", game_over, lives);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_death();
    int n;
    reset = 1'b1; tick_clk(); reset = 1'b0;
    n = 0;
    while (freeze === 1'b1 && n < 20) begin
      tick_clk(); n++;
    end
    lose = 1'b1; tick_clk(); lose = 1'b0; tick_clk();
    tick_clk(); tick_clk(); tick_clk();
    checks++;
    if (mario_dying !== 1'b1 || lives !== 4'd1 || dut_outs() !== model_outs()) begin
      errors++; $display("FAIL mid_death_setup dying=%b lives=%0d exp 1 1", mario_dying, lives);
    end
    reset = 1'b1; tick_clk(); reset = 1'b0;
    checks++;
    if (dut_outs() !== 13'b1100_0010_00010) begin
      errors++; $display("FAIL reset_mid_death got=%b exp=1100001000010", dut_outs());
    end
  endtask

  task automatic test_random();
    reset = 1'b1; tick_clk(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) lose = ~lose;
      start = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick_clk();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc_no, dut_outs(), model_outs());
      end
    end
    reset = 1'b0; lose = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_death();
    test_held_collision();
    test_game_over();
    test_continue();
    test_reset_mid_death();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
